auc_seq: RTL

AUC_SEQ -- requirements
Module: auc_seq

---
 rtl/auc_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/auc_seq.sv
// Signing sequencer: steps the AUC through RAND, WMUL, R, INVS, S with
// retry on r=0/s=0 errors, per-step timeout, and registered outputs.
module auc_seq #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned RETRY = 3,
   parameter logic [23:0] TMO   = 24'hFFFFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sg_start,
   input  logic             sg_curve,
   input  logic [WIDTH-1:0] sg_hash,
   input  logic [WIDTH-1:0] sg_pkey,
   output logic             sg_busy,
   output logic             sg_vld,
   output logic             sg_err,
   output logic [WIDTH-1:0] sg_r,
   output logic [WIDTH-1:0] sg_s,
   output logic [WIDTH-1:0] auc_dat,
   output logic             auc_start,
   output logic [3:0]       auc_mode,
   input  logic [WIDTH-1:0] auc_rslt,
   input  logic [1:0]       auc_status
);

   localparam int unsigned TW = 24;
   localparam int unsigned RW = (RETRY < 1) ? 1 : $clog2(RETRY + 1);

   localparam logic [2:0] OP_RAND = 3'b000;
   localparam logic [2:0] OP_WMUL = 3'b100;
   localparam logic [2:0] OP_R    = 3'b010;
   localparam logic [2:0] OP_INVS = 3'b001;
   localparam logic [2:0] OP_S    = 3'b011;

   localparam logic [1:0] AS_DONE = 2'b10;
   localparam logic [1:0] AS_ERR  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE0,
      ST_ISSUE1,
      ST_WAIT,
      ST_FIN
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       step_q, step_d;
   logic             curve_q, curve_d;
   logic [WIDTH-1:0] hash_q, hash_d;
   logic [WIDTH-1:0] pkey_q, pkey_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic [WIDTH-1:0] r_d, s_d;
   logic             err_q, err_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic [TW-1:0]    wcnt_q, wcnt_d;

   logic             busy_d, vld_d, sg_err_d, start_d, in_step;
   logic [3:0]       mode_d;
   logic [WIDTH-1:0] dat_d;

   // Next-state and next-output logic; outputs are derived from the next state
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      curve_d = curve_q;
      hash_d  = hash_q;
      pkey_d  = pkey_q;
      k_d     = k_q;
      r_d     = sg_r;
      s_d     = sg_s;
      err_d   = err_q;
      retry_d = retry_q;
      wcnt_d  = wcnt_q;

      case (state_q)
         ST_IDLE: begin
            if (sg_start) begin
               state_d = ST_ISSUE0;
               step_d  = OP_RAND;
               curve_d = sg_curve;
               hash_d  = sg_hash;
               pkey_d  = sg_pkey;
               retry_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_ISSUE0: state_d = ST_ISSUE1;
         ST_ISSUE1: state_d = ST_WAIT;
         ST_WAIT: begin
            if (auc_status == AS_DONE) begin
               state_d = ST_ISSUE0;
               case (step_q)
                  OP_RAND: begin k_d = auc_rslt; step_d = OP_WMUL; end
                  OP_WMUL: step_d = OP_R;
                  OP_R:    begin r_d = auc_rslt; step_d = OP_INVS; end
                  OP_INVS: step_d = OP_S;
                  default: begin s_d = auc_rslt; state_d = ST_FIN; err_d = 1'b0; end
               endcase
            end else if (auc_status == AS_ERR) begin
               // Only r=0 / s=0 are worth retrying with a fresh nonce
               if ((step_q == OP_R || step_q == OP_S) && retry_q != RW'(RETRY)) begin
                  retry_d = retry_q + RW'(1);
                  step_d  = OP_RAND;
                  state_d = ST_ISSUE0;
               end else begin
                  state_d = ST_FIN;
                  err_d   = 1'b1;
               end
            end else if ((wcnt_q + TW'(1)) >= TMO) begin
               state_d = ST_FIN;
               err_d   = 1'b1;
            end else begin
               wcnt_d = wcnt_q + TW'(1);
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_ISSUE0) wcnt_d = '0;

      in_step  = (state_d == ST_ISSUE0) || (state_d == ST_ISSUE1) || (state_d == ST_WAIT);
      busy_d   = (state_d != ST_IDLE);
      start_d  = (state_d == ST_ISSUE0);
      vld_d    = (state_d == ST_FIN);
      sg_err_d = vld_d & err_d;
      mode_d   = in_step ? {curve_d, step_d} : 4'h0;
      dat_d    = '0;
      if (state_d == ST_ISSUE0 && step_d == OP_S)         dat_d = hash_d;
      else if (state_d == ST_ISSUE1 && step_d == OP_S)    dat_d = pkey_d;
      else if (state_d == ST_ISSUE0 && step_d == OP_WMUL) dat_d = k_d;
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         step_q    <= OP_RAND;
         curve_q   <= 1'b0;
         hash_q    <= '0;
         pkey_q    <= '0;
         k_q       <= '0;
         err_q     <= 1'b0;
         retry_q   <= '0;
         wcnt_q    <= '0;
         sg_busy   <= 1'b0;
         sg_vld    <= 1'b0;
         sg_err    <= 1'b0;
         sg_r      <= '0;
         sg_s      <= '0;
         auc_dat   <= '0;
         auc_start <= 1'b0;
         auc_mode  <= 4'h0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         curve_q   <= curve_d;
         hash_q    <= hash_d;
         pkey_q    <= pkey_d;
         k_q       <= k_d;
         err_q     <= err_d;
         retry_q   <= retry_d;
         wcnt_q    <= wcnt_d;
         sg_busy   <= busy_d;
         sg_vld    <= vld_d;
         sg_err    <= sg_err_d;
         sg_r      <= r_d;
         sg_s      <= s_d;
         auc_dat   <= dat_d;
         auc_start <= start_d;
         auc_mode  <= mode_d;
      end
   end

endmodule
